median_window_ctrl: RTL and testbench

MEDIAN_WINDOW_CTRL -- requirements
Module: median_window_ctrl

---
 rtl/median_window_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_median_window_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_window_ctrl.sv
// median_window_ctrl: 3x3 window sequencer and output stage for a fixed-latency
// median core. Columns of three pixels stream in, 3x3 windows go out to the
// core, and the core results are re-aligned with their valid/last tags and
// presented on a valid/ready output port. A stalled output freezes the whole
// pipeline (core_en low), so nothing is lost or duplicated.
//
// Ports:
//   clk1, rst            clock, asynchronous active-high reset
//   col_valid/col_ready  column input handshake, col_data = {top, mid, bottom}
//   win_data/win_valid   3x3 window to the core, P1 in [71:64] .. P9 in [7:0]
//   core_en              core pipeline advance enable
//   core_med             core result, LAT enabled cycles after its window
//   out_valid/out_ready  filtered pixel handshake, out_pix / out_last payload
//
// Build option: define MEDIAN_CTRL_BORDER_REPLICATE_EN to replicate the first
// and last column of each row (COLS outputs per row, one FLUSH cycle per row);
// otherwise only interior columns are filtered (COLS-2 outputs per row).
module median_window_ctrl #(
  parameter int unsigned COLS = 16,
  parameter int unsigned LAT  = 3
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        col_valid,
  output logic        col_ready,
  input  logic [23:0] col_data,
  output logic [71:0] win_data,
  output logic        win_valid,
  output logic        core_en,
  input  logic [7:0]  core_med,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_pix,
  output logic        out_last
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

`ifdef MEDIAN_CTRL_BORDER_REPLICATE_EN
  localparam bit REPLICATE = 1'b1;
`else
  localparam bit REPLICATE = 1'b0;
`endif

  // Column index whose acceptance produces the first window of a row.
  localparam logic [CW-1:0] FIRST_WIN = REPLICATE ? CW'(1) : CW'(2);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [23:0]     col_m_q, col_m_d;   // column k-2 at acceptance of column k
  logic [23:0]     col_r_q, col_r_d;   // column k-1 at acceptance of column k
  logic [71:0]     win_data_q, win_data_d;
  logic            win_valid_q, win_valid_d;
  logic            win_last_q, win_last_d;
  logic [LAT-1:0]  tag_v_q, tag_v_d;
  logic [LAT-1:0]  tag_l_q, tag_l_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [7:0]      out_pix_q, out_pix_d;

  logic            accept;
  logic            is_last;
  logic            issue;
  logic            issue_last;
  logic [23:0]     w_l, w_c, w_r;

  // Whole pipeline advances only when the output register can take a value.
  assign core_en   = ~out_valid_q | out_ready;
  assign col_ready = core_en & (state_q != FLUSH) & ~rst;
  assign accept    = col_valid & col_ready;
  assign is_last   = (cnt_q == LAST_COL);

  assign win_data  = win_data_q;
  assign win_valid = win_valid_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_pix   = out_pix_q;

  // State register and datapath flops.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      col_m_q     <= '0;
      col_r_q     <= '0;
      win_data_q  <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      tag_v_q     <= '0;
      tag_l_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pix_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_m_q     <= col_m_d;
      col_r_q     <= col_r_d;
      win_data_q  <= win_data_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      tag_v_q     <= tag_v_d;
      tag_l_q     <= tag_l_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_pix_q   <= out_pix_d;
    end
  end

  // Row sequencing FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = FILL;
      FILL:  if (accept && (cnt_q == FIRST_WIN)) begin
               if (is_last) state_d = REPLICATE ? FLUSH : IDLE;
               else         state_d = RUN;
             end
      RUN:   if (accept && is_last) state_d = REPLICATE ? FLUSH : IDLE;
      FLUSH: if (core_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Column shift register, window selection, tag pipeline and output stage.
  always_comb begin
    cnt_d       = cnt_q;
    col_m_d     = col_m_q;
    col_r_d     = col_r_q;
    win_data_d  = win_data_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    tag_v_d     = tag_v_q;
    tag_l_d     = tag_l_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_pix_d   = out_pix_q;
    issue       = 1'b0;
    issue_last  = 1'b0;
    w_l         = col_m_q;
    w_c         = col_r_q;
    w_r         = col_data;

    if (accept) begin
      cnt_d   = is_last ? '0 : cnt_q + CW'(1);
      col_m_d = col_r_q;
      col_r_d = col_data;
    end

    // Window centred on the previously accepted column; FLUSH closes the row
    // with the last column standing in for its missing right neighbour.
    if (state_q == FLUSH) begin
      issue      = 1'b1;
      issue_last = 1'b1;
      w_r        = col_r_q;
    end else if (accept) begin
      if (REPLICATE) begin
        issue = (cnt_q != '0);
        if (cnt_q == CW'(1)) w_l = col_r_q;
      end else begin
        issue      = (cnt_q >= CW'(2));
        issue_last = is_last;
      end
    end

    if (core_en) begin
      win_valid_d = issue;
      win_last_d  = issue_last;
      if (issue) begin
        win_data_d = {w_l[23:16], w_c[23:16], w_r[23:16],
                      w_l[15:8],  w_c[15:8],  w_r[15:8],
                      w_l[7:0],   w_c[7:0],   w_r[7:0]};
      end
      tag_v_d[0] = win_valid_q;
      tag_l_d[0] = win_last_q;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_v_d[i] = tag_v_q[i-1];
        tag_l_d[i] = tag_l_q[i-1];
      end
      out_valid_d = tag_v_q[LAT-1];
      out_last_d  = tag_l_q[LAT-1];
      out_pix_d   = core_med;
    end
  end

endmodule

// File: tb/tb_median_window_ctrl.sv
// Self-checking bench for median_window_ctrl (COLS=4, LAT=3). A behavioural
// median core is attached; a reference model derives expected windows and
// output pixels from the accepted columns, and monitors compare against them.
module tb_median_window_ctrl;

  localparam int COLS = 4;
  localparam int LAT  = 3;
`ifdef MEDIAN_CTRL_BORDER_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  localparam int OUT_PER_ROW = REP ? COLS : COLS - 2;
  localparam int FIRST_CTR   = REP ? 0 : 1;
  localparam int LAST_CTR    = REP ? COLS - 1 : COLS - 2;
  localparam int FIRST_COL   = REP ? 1 : 2;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        col_valid;
  logic        col_ready;
  logic [23:0] col_data;
  logic [71:0] win_data;
  logic        win_valid;
  logic        core_en;
  logic [7:0]  core_med;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pix;
  logic        out_last;

  always #5 clk1 = ~clk1;

  median_window_ctrl #(.COLS(COLS), .LAT(LAT)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .col_data  (col_data),
    .win_data  (win_data),
    .win_valid (win_valid),
    .core_en   (core_en),
    .core_med  (core_med),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_last  (out_last)
  );

  function automatic logic [7:0] med9(input logic [71:0] w);
    logic [7:0] v [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) v[i] = w[8*(8-i) +: 8];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction

  // Behavioural median core: LAT enabled stages.
  logic [7:0] core_pipe [LAT];
  always @(posedge clk1) begin
    if (core_en) begin
      core_pipe[0] <= med9(win_data);
      for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
  end
  assign core_med = core_pipe[LAT-1];

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int n_out = 0;
  int out_idx = 0;
  int col_idx = 0;
  int acc_cyc = 0;
  int first_out_cyc = 0;
  int gaps = 0;
  bit gap_en = 1'b0;
  bit rand_en = 1'b0;

  logic [23:0] row_buf [COLS];
  logic [71:0] exp_win_q [$];
  logic [8:0]  exp_out_q [$];   // {last, pix}

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [71:0] pack_win(input logic [23:0] l, input logic [23:0] c,
                                            input logic [23:0] r);
    return {l[23:16], c[23:16], r[23:16], l[15:8], c[15:8], r[15:8], l[7:0], c[7:0], r[7:0]};
  endfunction

  // Output centred on column j needs columns j-1..j+1, clamped to the row.
  task automatic model_accept(input logic [23:0] d);
    int k, jl, jr;
    k = col_idx;
    row_buf[k] = d;
    for (int j = FIRST_CTR; j <= LAST_CTR; j++) begin
      jl = (j == 0) ? 0 : j - 1;
      jr = (j == COLS - 1) ? COLS - 1 : j + 1;
      if (jr == k) begin
        exp_win_q.push_back(pack_win(row_buf[jl], row_buf[j], row_buf[jr]));
        exp_out_q.push_back({(j == LAST_CTR), med9({row_buf[jl], row_buf[j], row_buf[jr]})});
      end
    end
    col_idx = (k == COLS - 1) ? 0 : k + 1;
  endtask

  // Monitor / scoreboard: samples on the falling edge, away from updates.
  initial forever begin
    @(negedge clk1);
    if (rst) begin
      exp_out_q.delete();
      exp_win_q.delete();
      col_idx = 0;
      out_idx = 0;
    end else begin
      if (win_valid && core_en) begin
        if (exp_win_q.size() == 0) fail_now("win_unexpected");
        else check("win_data", win_data, exp_win_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_out_q.size() == 0) fail_now("out_unexpected");
        else begin
          logic [8:0] e;
          e = exp_out_q.pop_front();
          check("out_pix", 72'(out_pix), 72'(e[7:0]));
          check("out_last", 72'(out_last), 72'(e[8]));
        end
        if (out_idx == 0) first_out_cyc = cyc;
        out_idx = (out_idx == OUT_PER_ROW - 1) ? 0 : out_idx + 1;
        n_out++;
      end
      if (col_valid && col_ready) begin
        if (col_idx == FIRST_COL) acc_cyc = cyc;
        model_accept(col_data);
      end
      if (gap_en && col_valid && !col_ready) gaps++;
    end
  end

  // Random output backpressure, active only in the random phase.
  initial forever begin
    @(posedge clk1);
    #1;
    if (rand_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send_col(input logic [23:0] d);
    int n;
    n = 0;
    col_valid = 1'b1;
    col_data  = d;
    forever begin
      @(negedge clk1);
      if (col_ready) break;
      n++;
      if (n > 200) begin fail_now("col_accept_timeout"); break; end
    end
    @(posedge clk1);
    #1;
  endtask

  task automatic send_rand_row();
    for (int c = 0; c < COLS; c++) send_col(24'($urandom()));
  endtask

  task automatic send_const_row(input logic [23:0] d);
    for (int c = 0; c < COLS; c++) send_col(d);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_out_q.size() != 0 || exp_win_q.size() != 0) && n < 300) begin
      @(negedge clk1);
      n++;
    end
    if (exp_out_q.size() != 0 || exp_win_q.size() != 0) fail_now("drain_timeout");
    repeat (3) @(posedge clk1);
    #1;
  endtask

  initial begin
    int n0;
    logic [7:0] held;
    int n;
    rst = 1'b1; col_valid = 1'b0; col_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    check("rst_col_ready", 72'(col_ready), 72'(0));
    check("rst_win_valid", 72'(win_valid), 72'(0));
    check("rst_out_valid", 72'(out_valid), 72'(0));
    check("rst_out_last",  72'(out_last),  72'(0));
    check("rst_win_data",  win_data,       72'(0));
    check("rst_out_pix",   72'(out_pix),   72'(0));
    @(posedge clk1); #1;
    rst = 1'b0;

    // Window content for columns {1,2,3}, {4,5,6}, {7,8,9}.
    send_col(24'h010203);
    send_col(24'h040506);
    send_col(24'h070809);
    col_valid = 1'b0;
    @(negedge clk1);
    check("first_win_valid", 72'(win_valid), 72'(1));
    check("first_win_data", win_data, 72'h01_04_07_02_05_08_03_06_09);
    @(posedge clk1); #1;
    send_col(24'h0a0b0c);
    col_valid = 1'b0;
    wait_drain();

    // Constant columns {10,20,30}: every output is 20; latency and end-of-row gap.
    n0 = n_out;
    send_const_row({8'd10, 8'd20, 8'd30});
    col_valid = 1'b0;
    @(negedge clk1);
    check("col_ready_after_last", 72'(col_ready), 72'(!REP));
    @(negedge clk1);
    check("col_ready_recovered", 72'(col_ready), 72'(1));
    @(posedge clk1); #1;
    wait_drain();
    check("row_out_count", 72'(n_out - n0), 72'(OUT_PER_ROW));
    // out_valid rises 4 edges after the accepting edge (acc_cyc + 1).
    check("first_out_latency", 72'(first_out_cyc - acc_cyc), 72'(5));

    // Output backpressure with columns waiting.
    n0 = n_out;
    out_ready = 1'b0;
    fork
      begin
        send_rand_row();
        send_rand_row();
        col_valid = 1'b0;
      end
      begin
        n = 0;
        do begin @(negedge clk1); n++; end while (!out_valid && n < 60);
        if (!out_valid) fail_now("stall_wait_timeout");
        held = out_pix;
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk1);
          check("stall_out_valid", 72'(out_valid), 72'(1));
          check("stall_out_pix",   72'(out_pix),   72'(held));
          check("stall_core_en",   72'(core_en),   72'(0));
          check("stall_col_ready", 72'(col_ready), 72'(0));
        end
        @(posedge clk1); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_out_count", 72'(n_out - n0), 72'(2 * OUT_PER_ROW));

    // Reset in the middle of a row.
    send_col(24'($urandom()));
    send_col(24'($urandom()));
    send_col(24'($urandom()));
    col_valid = 1'b0;
    @(posedge clk1); #1;
    rst = 1'b1;
    @(negedge clk1);
    check("midrow_rst_out_valid", 72'(out_valid), 72'(0));
    check("midrow_rst_col_ready", 72'(col_ready), 72'(0));
    @(posedge clk1); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk1);
    #1;
    n0 = n_out;
    send_rand_row();
    col_valid = 1'b0;
    wait_drain();
    check("post_rst_out_count", 72'(n_out - n0), 72'(OUT_PER_ROW));

    // Three rows back-to-back.
    n0 = n_out;
    gaps = 0;
    gap_en = 1'b1;
    send_rand_row();
    send_rand_row();
    send_rand_row();
    gap_en = 1'b0;
    col_valid = 1'b0;
    wait_drain();
    check("b2b_out_count", 72'(n_out - n0), 72'(3 * OUT_PER_ROW));
    check("b2b_ready_gaps", 72'(gaps), 72'(REP ? 2 : 0));

    // Random column gaps and random output backpressure.
    n0 = n_out;
    rand_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          col_valid = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk1);
          #1;
        end
        send_col(24'($urandom()));
      end
    end
    col_valid = 1'b0;
    rand_en = 1'b0;
    @(posedge clk1); #2;
    out_ready = 1'b1;
    wait_drain();
    check("rand_out_count", 72'(n_out - n0), 72'(8 * OUT_PER_ROW));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
